mux_guard: RTL and testbench



---
 rtl/mux_guard.sv | 147 ++++++++++++++
 tb/tb_mux_guard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_guard.sv
// Column select guard: break-before-make dead time, per-column on-time ceiling,
// row-start strobe and sticky fault reporting for the LED column multiplexer.
module mux_guard #(
  parameter int N_MUX         = 8,
  parameter int DEAD_CYCLES   = 10,
  parameter int MAX_ON_CYCLES = 500
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [N_MUX-1:0]         mux_in,
  input  logic                     fault_clr,
  output logic [N_MUX-1:0]         mux_out,
  output logic                     row_start,
  output logic [$clog2(N_MUX)-1:0] row_idx,
  output logic                     fault_timeout,
  output logic                     fault_illegal
);

  localparam int IW = $clog2(N_MUX);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int OW = $clog2(MAX_ON_CYCLES);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [OW-1:0] ON_LAST   = OW'(MAX_ON_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_DRIVE, S_TIMEOUT} state_t;

  function automatic logic [IW-1:0] f_index(input logic [N_MUX-1:0] sel);
    f_index = '0;
    for (int i = 0; i < N_MUX; i++) begin
      if (sel[i]) f_index = IW'(i);
    end
  endfunction

  state_t           r_state;
  logic [N_MUX-1:0] r_sel;
  logic [N_MUX-1:0] r_mux_out;
  logic             r_row_start;
  logic [IW-1:0]    r_row_idx;
  logic [DW-1:0]    r_dead_cnt;
  logic [OW-1:0]    r_on_cnt;
  logic             r_fault_to;
  logic             r_fault_ill;

  logic w_zero;
  logic w_multi;
  logic w_same;
  logic w_set_ill;
  logic w_set_to;

  assign w_zero    = (mux_in == '0);
  assign w_multi   = ((mux_in & (mux_in - N_MUX'(1))) != '0);
  assign w_same    = (mux_in == r_sel);
  assign w_set_ill = enable & w_multi;
  assign w_set_to  = enable & ~w_multi & (r_state == S_DRIVE) & w_same & (r_on_cnt == ON_LAST);

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_mux_out   <= '0;
      r_row_start <= 1'b0;
      r_row_idx   <= '0;
      r_dead_cnt  <= '0;
      r_on_cnt    <= '0;
    end else begin
      r_row_start <= 1'b0;
      if (!enable || w_multi) begin
        r_state   <= S_IDLE;
        r_mux_out <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_TIMEOUT: begin
            r_mux_out <= '0;
            if (r_state == S_TIMEOUT && w_same) begin
              r_state <= S_TIMEOUT;
            end else if (w_zero) begin
              r_state <= S_IDLE;
            end else begin
              r_sel      <= mux_in;
              r_row_idx  <= f_index(mux_in);
              r_dead_cnt <= '0;
              r_state    <= S_DEAD;
            end
          end
          S_DEAD: begin
            r_mux_out <= '0;
            if (w_zero) begin
              r_state <= S_IDLE;
            end else if (!w_same) begin
              r_sel      <= mux_in;
              r_row_idx  <= f_index(mux_in);
              r_dead_cnt <= '0;
            end else if (r_dead_cnt == DEAD_LAST) begin
              r_state     <= S_DRIVE;
              r_mux_out   <= r_sel;
              r_row_start <= 1'b1;
              r_on_cnt    <= '0;
            end else begin
              r_dead_cnt <= r_dead_cnt + DW'(1);
            end
          end
          S_DRIVE: begin
            if (w_zero) begin
              r_state   <= S_IDLE;
              r_mux_out <= '0;
            end else if (!w_same) begin
              // A new column always goes through dead time; never line-to-line.
              r_sel      <= mux_in;
              r_row_idx  <= f_index(mux_in);
              r_dead_cnt <= '0;
              r_state    <= S_DEAD;
              r_mux_out  <= '0;
            end else if (r_on_cnt == ON_LAST) begin
              r_state   <= S_TIMEOUT;
              r_mux_out <= '0;
            end else begin
              r_on_cnt <= r_on_cnt + OW'(1);
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_mux_out <= '0;
          end
        endcase
      end
    end
  end

  // A set event in the same cycle as fault_clr keeps the flag high.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_fault_to  <= 1'b0;
      r_fault_ill <= 1'b0;
    end else begin
      r_fault_to  <= w_set_to  | (r_fault_to  & ~fault_clr);
      r_fault_ill <= w_set_ill | (r_fault_ill & ~fault_clr);
    end
  end

  assign mux_out       = r_mux_out;
  assign row_start     = r_row_start;
  assign row_idx       = r_row_idx;
  assign fault_timeout = r_fault_to;
  assign fault_illegal = r_fault_ill;

endmodule

// File: tb/tb_mux_guard.sv
// Bench for mux_guard: directed vector table, async-reset sequence, rotating
// columns and randomized traffic against an age-based reference model.
module tb_mux_guard;

  localparam int D = 10;
  localparam int M = 500;

  logic       clk_50 = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] mux_in;
  logic       fault_clr;
  logic [7:0] mux_out;
  logic       row_start;
  logic [2:0] row_idx;
  logic       fault_timeout;
  logic       fault_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  mux_guard #(.N_MUX(8), .DEAD_CYCLES(D), .MAX_ON_CYCLES(M)) dut (
    .clk_50(clk_50), .rst(rst), .enable(enable), .mux_in(mux_in),
    .fault_clr(fault_clr), .mux_out(mux_out), .row_start(row_start),
    .row_idx(row_idx), .fault_timeout(fault_timeout), .fault_illegal(fault_illegal)
  );

  always #10 clk_50 = ~clk_50;

  // Reference model: a column is "active" from the cycle it is latched; it is
  // driven while its age lies in [D, D+M). Age saturates at D+M (timed out).
  logic       m_active;
  logic [7:0] m_lat;
  int         m_age;
  int         m_idx;
  logic       m_fto;
  logic       m_fill;

  function automatic void model_reset();
    m_active = 1'b0; m_lat = '0; m_age = 0; m_idx = 0; m_fto = 1'b0; m_fill = 1'b0;
  endfunction

  function automatic void model_update(input logic en, input logic [7:0] mi, input logic clr);
    logic multi;
    logic set_to;
    multi  = ($countones(mi) > 1);
    set_to = 1'b0;
    if (!en || multi || mi == 8'h00) begin
      m_active = 1'b0;
    end else if (m_active && mi == m_lat) begin
      if (m_age < D + M) begin
        m_age++;
        if (m_age == D + M) set_to = 1'b1;
      end
    end else begin
      m_active = 1'b1; m_lat = mi; m_age = 0; m_idx = $clog2(mi);
    end
    m_fill = (en && multi) || (m_fill && !clr);
    m_fto  = set_to || (m_fto && !clr);
  endfunction

  function automatic logic [13:0] model_vec();
    logic [7:0] o;
    o = (m_active && m_age >= D && m_age < D + M) ? m_lat : 8'h00;
    return {o, (m_active && m_age == D), 3'(m_idx), m_fto, m_fill};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {mux_out, row_start, row_idx, fault_timeout, fault_illegal};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h (out/rs/idx/fto/fill) expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [7:0] mi, input logic clr);
    enable = en; mux_in = mi; fault_clr = clr;
    @(posedge clk_50);
    #1;
    model_update(en, mi, clr);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; mux_in = '0; fault_clr = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;
    check("reset_state", dut_vec(), 14'h0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       en;
    logic [7:0] mi;
    logic       clr;
    int         n;
    logic [7:0] eo;
    logic       rs;
    logic [2:0] idx;
    logic       fto;
    logic       fill;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, input logic [7:0] mi, input logic clr, input int n,
                              input logic [7:0] eo, input logic rs, input logic [2:0] idx,
                              input logic fto, input logic fill);
    tbl.push_back('{en, mi, clr, n, eo, rs, idx, fto, fill});
  endfunction

  initial begin
    int cnt;
    logic [7:0] v;
    logic en;
    int len;
    int a;
    int b;

    // timeout on 0x04, then move to 0x08
    add(1, 8'h04, 0, 10,  8'h00, 0, 2, 0, 0);
    add(1, 8'h04, 0, 1,   8'h04, 1, 2, 0, 0);
    add(1, 8'h04, 0, 499, 8'h04, 0, 2, 0, 0);
    add(1, 8'h04, 0, 1,   8'h00, 0, 2, 1, 0);
    add(1, 8'h04, 0, 20,  8'h00, 0, 2, 1, 0);
    add(1, 8'h08, 0, 10,  8'h00, 0, 3, 1, 0);
    add(1, 8'h08, 0, 1,   8'h08, 1, 3, 1, 0);
    add(1, 8'h08, 0, 20,  8'h08, 0, 3, 1, 0);
    // illegal input during drive, clear, clear colliding with a new set
    add(1, 8'h11, 0, 1,   8'h00, 0, 3, 1, 1);
    add(1, 8'h00, 1, 1,   8'h00, 0, 3, 0, 0);
    add(1, 8'h11, 1, 1,   8'h00, 0, 3, 0, 1);
    add(1, 8'h00, 0, 3,   8'h00, 0, 3, 0, 1);
    add(1, 8'h00, 1, 1,   8'h00, 0, 3, 0, 0);
    // relatch during dead time, then abandon
    add(1, 8'h01, 0, 5,   8'h00, 0, 0, 0, 0);
    add(1, 8'h02, 0, 4,   8'h00, 0, 1, 0, 0);
    add(1, 8'h00, 0, 15,  8'h00, 0, 1, 0, 0);
    // enable dropped mid-drive, recovery needs a full dead period
    add(1, 8'h40, 0, 10,  8'h00, 0, 6, 0, 0);
    add(1, 8'h40, 0, 1,   8'h40, 1, 6, 0, 0);
    add(1, 8'h40, 0, 30,  8'h40, 0, 6, 0, 0);
    add(0, 8'h40, 0, 6,   8'h00, 0, 6, 0, 0);
    add(1, 8'h40, 0, 10,  8'h00, 0, 6, 0, 0);
    add(1, 8'h40, 0, 1,   8'h40, 1, 6, 0, 0);
    add(1, 8'h40, 0, 5,   8'h40, 0, 6, 0, 0);
    // direct column change from drive goes through dead time
    add(1, 8'h80, 0, 10,  8'h00, 0, 7, 0, 0);
    add(1, 8'h80, 0, 1,   8'h80, 1, 7, 0, 0);
    add(1, 8'h01, 0, 10,  8'h00, 0, 0, 0, 0);
    add(1, 8'h01, 0, 1,   8'h01, 1, 0, 0, 0);
    add(1, 8'h01, 0, 3,   8'h01, 0, 0, 0, 0);

    do_reset();
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].en, tbl[i].mi, tbl[i].clr);
        check($sformatf("vec%0d.%0d", i, k), dut_vec(),
              {tbl[i].eo, tbl[i].rs, tbl[i].idx, tbl[i].fto, tbl[i].fill});
      end
    end

    // asynchronous reset while driving 0x01
    #4;
    check("pre_rst_drive", {mux_out, 6'h0}, {8'h01, 6'h0});
    rst = 1'b1;
    #1;
    check("async_rst", dut_vec(), 14'h0);
    @(posedge clk_50);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 14; k++) begin
      step(1, 8'h01, 0);
      check($sformatf("rst_recover%0d", k), dut_vec(), model_vec());
    end

    // rotating columns every 501 cycles
    do_reset();
    for (int c = 0; c < 8; c++) begin
      v = 8'h01 << c;
      cnt = 0;
      for (int k = 0; k < 501; k++) begin
        step(1, v, 0);
        check("rot_model", dut_vec(), model_vec());
        if (mux_out == v) cnt++;
      end
      check($sformatf("rot_on_col%0d", c), 14'(cnt), 14'(491));
    end
    check("rot_no_fault", {12'h0, fault_timeout, fault_illegal}, 14'h0);

    // randomized traffic
    do_reset();
    for (int s = 0; s < 80; s++) begin
      en = ($urandom_range(0, 99) < 92);
      a  = $urandom_range(0, 19);
      if (a < 2) begin
        v = 8'h00;
      end else if (a == 2) begin
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        v = (8'h01 << a) | (8'h01 << b);
      end else begin
        v = 8'h01 << $urandom_range(0, 7);
      end
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(480, 560) : $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        step(en, v, ($urandom_range(0, 39) == 0));
        check("rand_model", dut_vec(), model_vec());
        check("rand_onehot", 14'($countones(mux_out) <= 1), 14'(1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
